addsub_accum_stage: RTL and testbench



---
 rtl/addsub_accum_stage.sv | 115 +++++++++++
 tb/tb_addsub_accum_stage.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_accum_stage.sv
// Rebuilds 13-bit add/sub results from sum+carry, accumulates them in groups of up to BEATS,
// and presents each group total on a valid/ready port. Define ACCUM_SAT_EN to saturate on overflow.
module addsub_accum_stage #(
  parameter int unsigned ACC_W = 24,
  parameter int unsigned BEATS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [11:0]      in_sum,
  input  logic             in_c12,
  input  logic             in_sub,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [7:0]       out_cnt,
  output logic             out_ovf
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACC,
    ST_HOLD
  } state_e;

  localparam logic [7:0]       BEATS_C = 8'(BEATS);
  localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic [12:0]      beat13;
  logic [ACC_W-1:0] ext;
  logic [ACC_W-1:0] sum_w;
  logic [ACC_W-1:0] acc_upd;
  logic             ovf_hit;
  logic             accept;

  // Subtract mode carries an inverted borrow in c12, so the true value is {~c12, sum} as signed.
  always_comb begin
    beat13  = in_sub ? {~in_c12, in_sum} : {in_c12, in_sum};
    ext     = in_sub ? {{(ACC_W-13){beat13[12]}}, beat13}
                     : {{(ACC_W-13){1'b0}}, beat13};
    sum_w   = acc_q + ext;
    ovf_hit = (acc_q[ACC_W-1] == ext[ACC_W-1]) && (sum_w[ACC_W-1] != acc_q[ACC_W-1]);
`ifdef ACCUM_SAT_EN
    acc_upd = ovf_hit ? (ext[ACC_W-1] ? SAT_MIN : SAT_MAX) : sum_w;
`else
    acc_upd = sum_w;
`endif
  end

  assign in_ready  = (state_q != ST_HOLD);
  assign out_valid = (state_q == ST_HOLD);
  assign accept    = in_valid && in_ready;
  assign out_acc   = acc_q;
  assign out_cnt   = cnt_q;
  assign out_ovf   = ovf_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          acc_d   = ext;
          cnt_d   = 8'd1;
          ovf_d   = 1'b0;
          state_d = ((BEATS_C == 8'd1) || in_last) ? ST_HOLD : ST_ACC;
        end
      end
      ST_ACC: begin
        if (accept) begin
          acc_d   = acc_upd;
          cnt_d   = cnt_q + 8'd1;
          ovf_d   = ovf_q | ovf_hit;
          if (((cnt_q + 8'd1) == BEATS_C) || in_last) begin
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_addsub_accum_stage.sv
// Self-checking bench: a 24-bit and a 14-bit accumulator share one input stream; expected
// totals come from an integer model of the group rules. Honours ACCUM_SAT_EN like the design.
module tb_addsub_accum_stage;

  localparam int W1 = 24;
  localparam int W2 = 14;
  localparam int NB = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [11:0]   in_sum = '0;
  logic          in_c12 = 1'b0;
  logic          in_sub = 1'b0;
  logic          in_last = 1'b0;
  logic          out_ready = 1'b1;

  logic          in_ready24, out_valid24, out_ovf24;
  logic [W1-1:0] out_acc24;
  logic [7:0]    out_cnt24;
  logic          in_ready14, out_valid14, out_ovf14;
  logic [W2-1:0] out_acc14;
  logic [7:0]    out_cnt14;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  addsub_accum_stage #(.ACC_W(W1), .BEATS(NB)) dut24 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready24),
    .in_sum(in_sum), .in_c12(in_c12), .in_sub(in_sub), .in_last(in_last),
    .out_valid(out_valid24), .out_ready(out_ready), .out_acc(out_acc24),
    .out_cnt(out_cnt24), .out_ovf(out_ovf24)
  );

  addsub_accum_stage #(.ACC_W(W2), .BEATS(NB)) dut14 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready14),
    .in_sum(in_sum), .in_c12(in_c12), .in_sub(in_sub), .in_last(in_last),
    .out_valid(out_valid14), .out_ready(out_ready), .out_acc(out_acc14),
    .out_cnt(out_cnt14), .out_ovf(out_ovf14)
  );

  // True arithmetic value of one add/sub result.
  function automatic longint ext_val(input bit c12, input bit [11:0] sum, input bit sub);
    if (!sub) return longint'(c12) * 4096 + longint'(sum);
    return c12 ? longint'(sum) : longint'(sum) - 4096;
  endfunction

  function automatic longint acc_step(input int w, input longint acc, input longint e,
                                      output bit ov);
    longint mx, mn, s;
    mx = (longint'(1) << (w - 1)) - 1;
    mn = -mx - 1;
    s  = acc + e;
    ov = (s > mx) || (s < mn);
    if (ov) begin
`ifdef ACCUM_SAT_EN
      s = (s > mx) ? mx : mn;
`else
      s = (s > mx) ? s - 2 * (mx + 1) : s + 2 * (mx + 1);
`endif
    end
    return s;
  endfunction

  // Called at a negedge; returns at the negedge after the beat was taken.
  task automatic send(input bit c12, input bit [11:0] sum, input bit sub, input bit last);
    int t;
    t = 0;
    in_valid = 1'b1; in_c12 = c12; in_sum = sum; in_sub = sub; in_last = last;
    while (in_ready24 !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      checks++; errors++;
      $display("FAIL send_timeout in_ready=%b required 1", in_ready24);
    end
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (out_valid24 !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid24); end
    checks++; if (in_ready24 !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready24); end
    checks++; if (out_acc24 !== '0) begin errors++; $display("FAIL reset_out_acc got %0h want 0", out_acc24); end
    checks++; if (out_cnt24 !== 8'd0) begin errors++; $display("FAIL reset_out_cnt got %0d want 0", out_cnt24); end
    checks++; if (out_ovf24 !== 1'b0) begin errors++; $display("FAIL reset_out_ovf got %b want 0", out_ovf24); end
  endtask

  task automatic test_add_group();
    out_ready = 1'b1;
    send(1'b0, 12'h00A, 1'b0, 1'b0);
    send(1'b1, 12'h000, 1'b0, 1'b0);
    send(1'b0, 12'hFFF, 1'b0, 1'b0);
    send(1'b0, 12'h001, 1'b0, 1'b0);
    checks++; if (out_valid24 !== 1'b1) begin errors++; $display("FAIL add_out_valid got %b want 1", out_valid24); end
    checks++; if (out_acc24 !== 24'd8202) begin errors++; $display("FAIL add_out_acc got %0d want 8202", out_acc24); end
    checks++; if (out_cnt24 !== 8'd4) begin errors++; $display("FAIL add_out_cnt got %0d want 4", out_cnt24); end
    checks++; if (out_ovf24 !== 1'b0) begin errors++; $display("FAIL add_out_ovf got %b want 0", out_ovf24); end
    checks++; if (in_ready24 !== 1'b0) begin errors++; $display("FAIL add_hold_in_ready got %b want 0", in_ready24); end
    // A beat offered during HOLD must not be taken on the handshake edge.
    in_valid = 1'b1; in_c12 = 1'b0; in_sum = 12'h007; in_sub = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid24 !== 1'b0) begin errors++; $display("FAIL add_bubble_out_valid got %b want 0", out_valid24); end
    checks++; if (in_ready24 !== 1'b1) begin errors++; $display("FAIL add_bubble_in_ready got %b want 1", in_ready24); end
    checks++; if (out_cnt24 !== 8'd0) begin errors++; $display("FAIL add_no_bypass_cnt got %0d want 0", out_cnt24); end
  endtask

  task automatic test_sub_group();
    out_ready = 1'b1;
    send(1'b0, 12'hFFF, 1'b1, 1'b0);
    send(1'b1, 12'h005, 1'b1, 1'b1);
    checks++; if (out_valid24 !== 1'b1) begin errors++; $display("FAIL sub_out_valid got %b want 1", out_valid24); end
    checks++; if (out_acc24 !== 24'd4) begin errors++; $display("FAIL sub_out_acc got %0d want 4", $signed(out_acc24)); end
    checks++; if (out_cnt24 !== 8'd2) begin errors++; $display("FAIL sub_out_cnt got %0d want 2", out_cnt24); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send(1'b0, 12'd100, 1'b0, 1'b0);
    send(1'b0, 12'd200, 1'b0, 1'b0);
    send(1'b0, 12'd300, 1'b0, 1'b1);
    in_valid = 1'b1; in_c12 = 1'b0; in_sum = 12'h021; in_sub = 1'b0; in_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++; if (out_valid24 !== 1'b1) begin errors++; $display("FAIL bp_out_valid[%0d] got %b want 1", i, out_valid24); end
      checks++; if (out_acc24 !== 24'd600) begin errors++; $display("FAIL bp_out_acc[%0d] got %0d want 600", i, out_acc24); end
      checks++; if (out_cnt24 !== 8'd3) begin errors++; $display("FAIL bp_out_cnt[%0d] got %0d want 3", i, out_cnt24); end
      checks++; if (in_ready24 !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d] got %b want 0", i, in_ready24); end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_valid24 !== 1'b0) begin errors++; $display("FAIL bp_release_out_valid got %b want 0", out_valid24); end
    checks++; if (out_cnt24 !== 8'd0) begin errors++; $display("FAIL bp_release_cnt got %0d want 0", out_cnt24); end
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_cnt24 !== 8'd1) begin errors++; $display("FAIL bp_pending_cnt got %0d want 1", out_cnt24); end
    checks++; if (out_acc24 !== 24'd33) begin errors++; $display("FAIL bp_pending_acc got %0d want 33", out_acc24); end
    send(1'b0, 12'd1, 1'b0, 1'b1);
    checks++; if (out_acc24 !== 24'd34 || out_cnt24 !== 8'd2) begin
      errors++; $display("FAIL bp_next_group got acc=%0d cnt=%0d want acc=34 cnt=2", out_acc24, out_cnt24);
    end
    @(negedge clk);
  endtask

  task automatic test_overflow14();
    longint exp14, e;
    bit     ov, ov_any;
`ifdef ACCUM_SAT_EN
    exp14 = 8191;
`else
    exp14 = -4099;
`endif
    out_ready = 1'b1;
    send(1'b0, 12'hFFF, 1'b0, 1'b0);
    send(1'b0, 12'hFFF, 1'b0, 1'b0);
    send(1'b0, 12'hFFF, 1'b0, 1'b1);
    checks++; if (out_acc14 !== W2'(exp14)) begin errors++; $display("FAIL ovf14_acc got %0d want %0d", $signed(out_acc14), exp14); end
    checks++; if (out_ovf14 !== 1'b1) begin errors++; $display("FAIL ovf14_flag got %b want 1", out_ovf14); end
    checks++; if (out_acc24 !== 24'd12285 || out_ovf24 !== 1'b0) begin
      errors++; $display("FAIL ovf24_no_ovf got acc=%0d ovf=%b want 12285/0", out_acc24, out_ovf24);
    end
    @(negedge clk);
    e = ext_val(1'b1, 12'hFFF, 1'b0);
    exp14 = e; ov_any = 1'b0;
    for (int i = 0; i < 2; i++) begin
      exp14 = acc_step(W2, exp14, e, ov);
      ov_any |= ov;
    end
    send(1'b1, 12'hFFF, 1'b0, 1'b0);
    send(1'b1, 12'hFFF, 1'b0, 1'b0);
    send(1'b1, 12'hFFF, 1'b0, 1'b1);
    checks++; if (out_acc14 !== W2'(exp14) || out_ovf14 !== ov_any) begin
      errors++; $display("FAIL ovf14_max got acc=%0d ovf=%b want %0d/%b", $signed(out_acc14), out_ovf14, exp14, ov_any);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    send(1'b0, 12'd50, 1'b0, 1'b0);
    send(1'b0, 12'd50, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (out_valid24 !== 1'b0 || in_ready24 !== 1'b1 || out_cnt24 !== 8'd0 || out_acc24 !== '0) begin
      errors++; $display("FAIL rstmid_state got v=%b r=%b cnt=%0d acc=%0d want 0/1/0/0", out_valid24, in_ready24, out_cnt24, out_acc24);
    end
    for (int i = 0; i < 4; i++) send(1'b0, 12'd1, 1'b0, 1'b0);
    checks++; if (out_valid24 !== 1'b1) begin errors++; $display("FAIL rstmid_out_valid got %b want 1", out_valid24); end
    checks++; if (out_acc24 !== 24'd4) begin errors++; $display("FAIL rstmid_out_acc got %0d want 4", out_acc24); end
    checks++; if (out_cnt24 !== 8'd4) begin errors++; $display("FAIL rstmid_out_cnt got %0d want 4", out_cnt24); end
    checks++; if (out_ovf24 !== 1'b0) begin errors++; $display("FAIL rstmid_out_ovf got %b want 0", out_ovf24); end
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int g = 0; g < 40; g++) begin
      longint a24, a14, e;
      bit     o24, o14, ov, c12, sub, last;
      bit [11:0] sum;
      int     cnt;
      out_ready = 1'b0;
      cnt = 0; a24 = 0; a14 = 0; o24 = 0; o14 = 0; last = 0;
      while (cnt < NB && !last) begin
        c12  = 1'($urandom);
        sub  = 1'($urandom);
        sum  = 12'($urandom);
        last = (cnt + 1 < NB) && ($urandom_range(0, 4) == 0);
        e = ext_val(c12, sum, sub);
        if (cnt == 0) begin
          a24 = e; a14 = e;
        end else begin
          a24 = acc_step(W1, a24, e, ov); o24 |= ov;
          a14 = acc_step(W2, a14, e, ov); o14 |= ov;
        end
        cnt++;
        send(c12, sum, sub, last);
        if (cnt < NB && !last) repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      checks++; if (out_valid24 !== 1'b1) begin errors++; $display("FAIL rnd%0d_out_valid got %b want 1", g, out_valid24); end
      checks++; if (out_cnt24 !== 8'(cnt)) begin errors++; $display("FAIL rnd%0d_cnt got %0d want %0d", g, out_cnt24, cnt); end
      checks++; if (out_acc24 !== W1'(a24) || out_ovf24 !== o24) begin
        errors++; $display("FAIL rnd%0d_acc24 got %0d/%b want %0d/%b", g, $signed(out_acc24), out_ovf24, a24, o24);
      end
      checks++; if (out_acc14 !== W2'(a14) || out_ovf14 !== o14) begin
        errors++; $display("FAIL rnd%0d_acc14 got %0d/%b want %0d/%b", g, $signed(out_acc14), out_ovf14, a14, o14);
      end
      out_ready = 1'b1;
      @(negedge clk);
    end
    out_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_add_group();
    test_sub_group();
    test_backpressure();
    test_overflow14();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

endmodule
